// File: rtl/riot_pkg.sv
// Shared constants and types for the RIOT-style I/O/timer block.
// Holds the address field positions, prescale code enum and its divide
// constants, flag bit positions in the status byte, and a helper that maps
// a prescale code to the terminal value of the prescale counter.
package riot_pkg;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 8;

  // Address field positions
  localparam int unsigned A_WIN_BIT  = 4;  // 0 = port window, 1 = timer window
  localparam int unsigned A_IEN_BIT  = 3;  // timer IRQ enable on timer access
  localparam int unsigned A_TSEL_BIT = 2;  // timer vs flag/edge-control
  localparam int unsigned A_HI_BIT   = 1;  // timer high byte on read
  localparam int unsigned A_SEL_BIT  = 0;  // port: data/DDR, timer window: flag read
  localparam int unsigned A_PORT_MSB = 3;
  localparam int unsigned A_PORT_LSB = 1;
  localparam int unsigned A_PS_MSB   = 1;
  localparam int unsigned A_PS_LSB   = 0;
  localparam int unsigned A_EPOL_BIT = 0;  // edge polarity, 1 = rising
  localparam int unsigned A_EIEN_BIT = 1;  // edge IRQ enable

  typedef enum logic [1:0] {
    PS_1    = 2'b00,
    PS_8    = 2'b01,
    PS_64   = 2'b10,
    PS_1024 = 2'b11
  } prescale_e;

  localparam int unsigned DIV_1    = 1;
  localparam int unsigned DIV_8    = 8;
  localparam int unsigned DIV_64   = 64;
  localparam int unsigned DIV_1024 = 1024;
  localparam int unsigned PCNT_W   = 10;

  localparam int unsigned TFLAG_BIT = 7;
  localparam int unsigned EFLAG_BIT = 6;

  // Last value of the prescale counter before the timer decrements
  function automatic logic [PCNT_W-1:0] ps_terminal(input prescale_e ps);
    logic [PCNT_W-1:0] t;
    t = '0;
    case (ps)
      PS_1:    t = PCNT_W'(DIV_1 - 1);
      PS_8:    t = PCNT_W'(DIV_8 - 1);
      PS_64:   t = PCNT_W'(DIV_64 - 1);
      PS_1024: t = PCNT_W'(DIV_1024 - 1);
      default: t = '0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/riot_io_timer_if.sv
// CPU-side bus of the RIOT I/O/timer block.
// master: cs, we_n, A, DI out; DO, OE in.  slave: the reverse.
interface riot_io_timer_if;
  logic                        cs;
  logic                        we_n;
  logic [riot_pkg::ADDR_W-1:0] A;
  logic [riot_pkg::DATA_W-1:0] DI;
  logic [riot_pkg::DATA_W-1:0] DO;
  logic                        OE;

  modport master (output cs, we_n, A, DI, input DO, OE);
  modport slave  (input cs, we_n, A, DI, output DO, OE);
endinterface

// File: rtl/riot_timer.sv
// Interval timer: prescale counter, down counter, fast-count after underflow
// and the timer flag. Stays frozen after reset until first loaded.
// Ports:
//   phi2, rst       clock, synchronous active-high reset
//   i_load          timer write strobe (loads value, prescale, clears flag)
//   i_load_val      value to load, zero-extended
//   i_ps            prescale code to load
//   i_clr_flag      timer read strobe (clears flag unless it sets this cycle)
//   o_timer         current timer value
//   o_flag          timer flag
module riot_timer
  import riot_pkg::*;
#(
  parameter int unsigned TIMER_W = 8
) (
  input  logic               phi2,
  input  logic               rst,
  input  logic               i_load,
  input  logic [7:0]         i_load_val,
  input  prescale_e          i_ps,
  input  logic               i_clr_flag,
  output logic [TIMER_W-1:0] o_timer,
  output logic               o_flag
);

  logic [PCNT_W-1:0]  r_pcnt;
  prescale_e          r_ps;
  logic               r_run;
  logic [TIMER_W-1:0] r_timer;
  logic               r_flag;

  logic w_tick;
  logic w_under;

  // Once the flag is up the timer decrements every cycle
  assign w_tick  = r_run & (r_flag | (r_pcnt == ps_terminal(r_ps)));
  assign w_under = w_tick & (r_timer == '0);

  // Load beats a same-cycle underflow; a set beats a same-cycle clear
  always_ff @(posedge phi2) begin
    if (rst) begin
      r_pcnt  <= '0;
      r_ps    <= PS_1;
      r_run   <= 1'b0;
      r_timer <= '0;
      r_flag  <= 1'b0;
    end else if (i_load) begin
      r_timer <= TIMER_W'(i_load_val);
      r_ps    <= i_ps;
      r_pcnt  <= '0;
      r_flag  <= 1'b0;
      r_run   <= 1'b1;
    end else begin
      if (w_tick) begin
        r_timer <= r_timer - TIMER_W'(1);
        r_pcnt  <= '0;
      end else if (r_run) begin
        r_pcnt <= r_pcnt + PCNT_W'(1);
      end
      if (w_under) begin
        r_flag <= 1'b1;
      end else if (i_clr_flag) begin
        r_flag <= 1'b0;
      end
    end
  end

  assign o_timer = r_timer;
  assign o_flag  = r_flag;

endmodule

// File: rtl/riot_io_timer.sv
// RIOT-style I/O/timer: N_PORTS 8-bit ports with direction registers, an
// interval timer, optional PA7-style edge detector and an active-low IRQ.
// Optional feature macro: RIOT_EDGE_IRQ_EN (edge detector, edge flag and
// edge control present when defined; edge flag reads 0 otherwise).
// Ports:
//   phi2, rst   clock, synchronous active-high reset
//   bus         CPU bus (cs, we_n, A, DI in; DO, OE registered out)
//   PI          pin inputs, port p at [8p+7:8p]
//   PO, DDR     port output data and direction (1 = output)
//   irq_n       registered active-low interrupt
module riot_io_timer
  import riot_pkg::*;
#(
  parameter int unsigned N_PORTS   = 2,
  parameter int unsigned TIMER_W   = 8,
  parameter int unsigned EDGE_PORT = 0
) (
  input  logic                 phi2,
  input  logic                 rst,
  riot_io_timer_if.slave       bus,
  input  logic [8*N_PORTS-1:0] PI,
  output logic [8*N_PORTS-1:0] PO,
  output logic [8*N_PORTS-1:0] DDR,
  output logic                 irq_n
);

  logic [DATA_W-1:0] r_po  [N_PORTS];
  logic [DATA_W-1:0] r_ddr [N_PORTS];
  logic [DATA_W-1:0] r_do;
  logic              r_oe;
  logic              r_irq_n;
  logic              r_ten;

  logic               w_rd;
  logic               w_wr;
  logic               w_twin;
  logic [2:0]         w_port;
  logic               w_pwr;
  logic               w_tload;
  logic               w_tread;
  logic               w_fread;
  prescale_e          w_ps;
  logic [TIMER_W-1:0] w_timer;
  logic [15:0]        w_t16;
  logic               w_tflag;
  logic               w_eflag;
  logic               w_eirq;
  logic [DATA_W-1:0]  w_rdata;

  // Access decode
  assign w_rd    = bus.cs & bus.we_n;
  assign w_wr    = bus.cs & ~bus.we_n;
  assign w_twin  = bus.A[A_WIN_BIT];
  assign w_port  = bus.A[A_PORT_MSB:A_PORT_LSB];
  assign w_pwr   = w_wr & ~w_twin;
  assign w_tload = w_wr & w_twin & bus.A[A_TSEL_BIT];
  assign w_tread = w_rd & w_twin & bus.A[A_TSEL_BIT] & ~bus.A[A_SEL_BIT];
  assign w_fread = w_rd & w_twin & ~bus.A[A_TSEL_BIT] & bus.A[A_SEL_BIT];
  assign w_ps    = prescale_e'(bus.A[A_PS_MSB:A_PS_LSB]);

  riot_timer #(.TIMER_W(TIMER_W)) u_timer (
    .phi2       (phi2),
    .rst        (rst),
    .i_load     (w_tload),
    .i_load_val (bus.DI),
    .i_ps       (w_ps),
    .i_clr_flag (w_tread),
    .o_timer    (w_timer),
    .o_flag     (w_tflag)
  );

  assign w_t16 = 16'(w_timer);

`ifdef RIOT_EDGE_IRQ_EN
  logic r_eprev;
  logic r_epol;
  logic r_een;
  logic r_eflag;
  logic w_pin;
  logic w_edge;
  logic w_ectl;

  // Watched pin is seen through DDR, so an output bit follows PO
  assign w_pin  = r_ddr[EDGE_PORT][7] ? r_po[EDGE_PORT][7] : PI[8*EDGE_PORT+7];
  assign w_edge = r_epol ? (~r_eprev & w_pin) : (r_eprev & ~w_pin);
  assign w_ectl = w_wr & w_twin & ~bus.A[A_TSEL_BIT];

  always_ff @(posedge phi2) begin
    if (rst) begin
      r_eprev <= 1'b0;
      r_epol  <= 1'b0;
      r_een   <= 1'b0;
      r_eflag <= 1'b0;
    end else begin
      r_eprev <= w_pin;
      if (w_edge) begin
        r_eflag <= 1'b1;
      end else if (w_fread) begin
        r_eflag <= 1'b0;
      end
      if (w_ectl) begin
        r_epol <= bus.A[A_EPOL_BIT];
        r_een  <= bus.A[A_EIEN_BIT];
      end
    end
  end

  assign w_eflag = r_eflag;
  assign w_eirq  = r_eflag & r_een;
`else
  assign w_eflag = 1'b0;
  assign w_eirq  = 1'b0;
`endif

  // Read data mux; unpopulated ports and unused timer codes read 0
  always_comb begin
    w_rdata = '0;
    if (!w_twin) begin
      for (int unsigned p = 0; p < N_PORTS; p++) begin
        if (w_port == 3'(p)) begin
          if (bus.A[A_SEL_BIT]) begin
            w_rdata = r_ddr[p];
          end else begin
            w_rdata = (r_ddr[p] & r_po[p]) | (~r_ddr[p] & PI[8*p +: 8]);
          end
        end
      end
    end else if (bus.A[A_TSEL_BIT] && !bus.A[A_SEL_BIT]) begin
      w_rdata = (bus.A[A_HI_BIT] && (TIMER_W > 8)) ? w_t16[15:8] : w_t16[7:0];
    end else if (!bus.A[A_TSEL_BIT] && bus.A[A_SEL_BIT]) begin
      w_rdata[TFLAG_BIT] = w_tflag;
      w_rdata[EFLAG_BIT] = w_eflag;
    end
  end

  // Port registers, read port, timer IRQ enable and interrupt output
  always_ff @(posedge phi2) begin
    if (rst) begin
      for (int unsigned p = 0; p < N_PORTS; p++) begin
        r_po[p]  <= '0;
        r_ddr[p] <= '0;
      end
      r_do    <= '0;
      r_oe    <= 1'b0;
      r_irq_n <= 1'b1;
      r_ten   <= 1'b0;
    end else begin
      for (int unsigned p = 0; p < N_PORTS; p++) begin
        if (w_pwr && (w_port == 3'(p))) begin
          if (bus.A[A_SEL_BIT]) begin
            r_ddr[p] <= bus.DI;
          end else begin
            r_po[p] <= bus.DI;
          end
        end
      end
      r_oe <= w_rd;
      if (w_rd) begin
        r_do <= w_rdata;
      end
      if (w_tload || w_tread) begin
        r_ten <= bus.A[A_IEN_BIT];
      end
      r_irq_n <= ~((w_tflag & r_ten) | w_eirq);
    end
  end

  for (genvar g = 0; g < N_PORTS; g++) begin : g_port
    assign PO[8*g +: 8]  = r_po[g];
    assign DDR[8*g +: 8] = r_ddr[g];
  end

  assign bus.DO = r_do;
  assign bus.OE = r_oe;
  assign irq_n  = r_irq_n;

endmodule

// File: tb/tb_riot_io_timer.sv
// Self-checking bench for riot_io_timer: directed scenarios with fixed
// expectations plus a randomized run against a behavioural model.
`timescale 1ns/1ps
module tb_riot_io_timer;

  localparam int NP = 2;
  localparam int TW = 8;
`ifdef RIOT_EDGE_IRQ_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif

  logic            phi2 = 1'b0;
  logic            rst;
  logic [8*NP-1:0] pi;
  logic [8*NP-1:0] po;
  logic [8*NP-1:0] ddr;
  logic            irq_n;

  riot_io_timer_if bus();

  riot_io_timer #(.N_PORTS(NP), .TIMER_W(TW), .EDGE_PORT(0)) dut (
    .phi2  (phi2),
    .rst   (rst),
    .bus   (bus),
    .PI    (pi),
    .PO    (po),
    .DDR   (ddr),
    .irq_n (irq_n)
  );

  always #5 phi2 = ~phi2;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model state
  logic [7:0] m_po [NP];
  logic [7:0] m_ddr[NP];
  logic [7:0] m_do;
  logic       m_oe, m_irq_n, m_run, m_tflag, m_ten, m_eflag, m_een, m_epol, m_eprev;
  int         m_timer, m_div, m_pcnt;

  task automatic model_step(input logic r, input logic c, input logic w,
                            input logic [4:0] a, input logic [7:0] di,
                            input logic [8*NP-1:0] pv);
    logic [7:0] rd;
    int p;
    logic pin, ev, tick, under, irq, wr, rda, tread, fread;
    if (r) begin
      for (int i = 0; i < NP; i++) begin m_po[i] = 8'h00; m_ddr[i] = 8'h00; end
      m_do = 8'h00; m_oe = 1'b0; m_irq_n = 1'b1; m_run = 1'b0;
      m_timer = 0; m_div = 1; m_pcnt = 0; m_tflag = 1'b0; m_ten = 1'b0;
      m_eflag = 1'b0; m_een = 1'b0; m_epol = 1'b0; m_eprev = 1'b0;
      return;
    end
    wr    = c && !w;
    rda   = c && w;
    tread = rda && a[4] && a[2] && !a[0];
    fread = rda && a[4] && !a[2] && a[0];
    p     = int'(a[3:1]);
    rd    = 8'h00;
    if (!a[4]) begin
      if (p < NP)
        rd = a[0] ? m_ddr[p] : ((m_ddr[p] & m_po[p]) | (~m_ddr[p] & pv[8*p +: 8]));
    end else if (a[2] && !a[0]) begin
      rd = (a[1] && TW > 8) ? 8'((m_timer >> 8) & 255) : 8'(m_timer & 255);
    end else if (!a[2] && a[0]) begin
      rd = {m_tflag, m_eflag, 6'b0};
    end
    irq   = (m_tflag && m_ten) || (m_eflag && m_een);
    pin   = m_ddr[0][7] ? m_po[0][7] : pv[7];
    ev    = EDGE_EN && (m_epol ? (!m_eprev && pin) : (m_eprev && !pin));
    tick  = m_run && (m_tflag || (m_pcnt == m_div - 1));
    under = tick && (m_timer == 0);

    m_oe = rda;
    if (rda) m_do = rd;
    m_irq_n = !irq;
    if (wr && !a[4] && p < NP) begin
      if (a[0]) m_ddr[p] = di; else m_po[p] = di;
    end
    if (wr && a[4] && a[2]) begin
      m_timer = int'(di);
      case (a[1:0])
        2'd0: m_div = 1;
        2'd1: m_div = 8;
        2'd2: m_div = 64;
        default: m_div = 1024;
      endcase
      m_ten = a[3]; m_tflag = 1'b0; m_pcnt = 0; m_run = 1'b1;
    end else begin
      if (tick) begin
        m_timer = (m_timer == 0) ? (1 << TW) - 1 : m_timer - 1;
        m_pcnt  = 0;
      end else if (m_run) begin
        m_pcnt++;
      end
      if (under) m_tflag = 1'b1;
      else if (tread) m_tflag = 1'b0;
      if (tread) m_ten = a[3];
    end
    if (EDGE_EN) begin
      m_eprev = pin;
      if (ev) m_eflag = 1'b1;
      else if (fread) m_eflag = 1'b0;
      if (wr && a[4] && !a[2]) begin m_epol = a[0]; m_een = a[1]; end
    end
  endtask

  // One bus cycle: drive on negedge, advance model on posedge, settle 1ns
  task automatic cyc(input logic r, input logic c, input logic w,
                     input logic [4:0] a, input logic [7:0] di);
    @(negedge phi2);
    rst = r; bus.cs = c; bus.we_n = w; bus.A = a; bus.DI = di;
    @(posedge phi2);
    model_step(r, c, w, a, di, pi);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b1, 5'h00, 8'h00);
  endtask

  task automatic test_reset();
    pi = '0;
    cyc(1'b1, 1'b0, 1'b1, 5'h00, 8'h00);
    cyc(1'b1, 1'b1, 1'b1, 5'h00, 8'h00);
    n_vec++; if (bus.DO !== 8'h00) begin n_err++; $display("FAIL reset_do got %h want 00", bus.DO); end
    n_vec++; if (bus.OE !== 1'b0) begin n_err++; $display("FAIL reset_oe got %b want 0", bus.OE); end
    n_vec++; if (irq_n !== 1'b1) begin n_err++; $display("FAIL reset_irq_n got %b want 1", irq_n); end
    n_vec++; if (po !== 16'h0000) begin n_err++; $display("FAIL reset_po got %h want 0000", po); end
    n_vec++; if (ddr !== 16'h0000) begin n_err++; $display("FAIL reset_ddr got %h want 0000", ddr); end
  endtask

  task automatic test_port_rw();
    cyc(1'b1, 1'b0, 1'b1, 5'h00, 8'h00);
    pi = 16'h003C;
    cyc(1'b0, 1'b1, 1'b0, 5'h01, 8'hF0);
    cyc(1'b0, 1'b1, 1'b0, 5'h00, 8'hA5);
    cyc(1'b0, 1'b1, 1'b1, 5'h00, 8'h00);
    n_vec++; if (bus.DO !== 8'hAC) begin n_err++; $display("FAIL port0_read got %h want ac", bus.DO); end
    n_vec++; if (bus.OE !== 1'b1) begin n_err++; $display("FAIL port0_oe got %b want 1", bus.OE); end
    idle(1);
    n_vec++; if (bus.OE !== 1'b0) begin n_err++; $display("FAIL oe_drop got %b want 0", bus.OE); end
    cyc(1'b0, 1'b1, 1'b0, 5'h0A, 8'h55);   // port 5 does not exist
    cyc(1'b0, 1'b0, 1'b0, 5'h00, 8'hFF);   // cs low: no write
    n_vec++; if (po !== 16'h00A5) begin n_err++; $display("FAIL port_ignored_wr got %h want 00a5", po); end
    n_vec++; if (ddr !== 16'h00F0) begin n_err++; $display("FAIL ddr0 got %h want 00f0", ddr); end
    cyc(1'b0, 1'b1, 1'b1, 5'h0A, 8'h00);
    n_vec++; if (bus.DO !== 8'h00) begin n_err++; $display("FAIL port5_read got %h want 00", bus.DO); end
    cyc(1'b0, 1'b1, 1'b1, 5'h01, 8'h00);
    n_vec++; if (bus.DO !== 8'hF0) begin n_err++; $display("FAIL ddr0_read got %h want f0", bus.DO); end
  endtask

  task automatic test_timer_underflow();
    cyc(1'b1, 1'b0, 1'b1, 5'h00, 8'h00);
    cyc(1'b0, 1'b1, 1'b0, 5'h1D, 8'h03);   // prescale 8, IRQ enabled
    idle(31);
    n_vec++; if (irq_n !== 1'b1) begin n_err++; $display("FAIL tmr_early_irq got %b want 1", irq_n); end
    idle(1);
    n_vec++; if (irq_n !== 1'b1) begin n_err++; $display("FAIL tmr_at_uf_irq got %b want 1", irq_n); end
    cyc(1'b0, 1'b1, 1'b1, 5'h1C, 8'h00);
    n_vec++; if (bus.DO !== 8'hFF) begin n_err++; $display("FAIL tmr_rd_ff got %h want ff", bus.DO); end
    n_vec++; if (irq_n !== 1'b0) begin n_err++; $display("FAIL tmr_irq_low got %b want 0", irq_n); end
    cyc(1'b0, 1'b1, 1'b1, 5'h1C, 8'h00);
    n_vec++; if (bus.DO !== 8'hFE) begin n_err++; $display("FAIL tmr_rd_fe got %h want fe", bus.DO); end
    n_vec++; if (irq_n !== 1'b1) begin n_err++; $display("FAIL tmr_irq_cleared got %b want 1", irq_n); end
  endtask

  task automatic test_read_clear();
    cyc(1'b1, 1'b0, 1'b1, 5'h00, 8'h00);
    cyc(1'b0, 1'b1, 1'b0, 5'h1D, 8'h00);
    idle(10);
    n_vec++; if (irq_n !== 1'b0) begin n_err++; $display("FAIL rc_irq_low got %b want 0", irq_n); end
    cyc(1'b0, 1'b1, 1'b1, 5'h1C, 8'h00);
    n_vec++; if (bus.DO !== 8'hFD) begin n_err++; $display("FAIL rc_fast_value got %h want fd", bus.DO); end
    n_vec++; if (irq_n !== 1'b0) begin n_err++; $display("FAIL rc_irq_still_low got %b want 0", irq_n); end
    idle(1);
    n_vec++; if (irq_n !== 1'b1) begin n_err++; $display("FAIL rc_irq_high got %b want 1", irq_n); end
  endtask

  task automatic test_write_at_underflow();
    int bad;
    cyc(1'b1, 1'b0, 1'b1, 5'h00, 8'h00);
    cyc(1'b0, 1'b1, 1'b0, 5'h1D, 8'h01);
    idle(15);
    cyc(1'b0, 1'b1, 1'b0, 5'h1F, 8'h00);   // lands on the underflow cycle
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      idle(1);
      if (irq_n !== 1'b1) bad++;
    end
    n_vec++; if (bad != 0) begin n_err++; $display("FAIL wuf_irq got %0d low cycles want 0", bad); end
    cyc(1'b0, 1'b1, 1'b1, 5'h11, 8'h00);
    n_vec++; if (bus.DO !== 8'h00) begin n_err++; $display("FAIL wuf_flags got %h want 00", bus.DO); end
    cyc(1'b0, 1'b1, 1'b1, 5'h1C, 8'h00);
    n_vec++; if (bus.DO !== 8'h00) begin n_err++; $display("FAIL wuf_timer got %h want 00", bus.DO); end
  endtask

  task automatic test_edge();
    cyc(1'b1, 1'b0, 1'b1, 5'h00, 8'h00);
    pi = 16'h0000;
    cyc(1'b0, 1'b1, 1'b0, 5'h13, 8'h00);   // rising, enabled
    idle(1);
    pi = 16'h0080;
    idle(2);
`ifdef RIOT_EDGE_IRQ_EN
    n_vec++; if (irq_n !== 1'b0) begin n_err++; $display("FAIL edge_irq got %b want 0", irq_n); end
    cyc(1'b0, 1'b1, 1'b1, 5'h11, 8'h00);
    n_vec++; if (bus.DO !== 8'h40) begin n_err++; $display("FAIL edge_flag got %h want 40", bus.DO); end
    cyc(1'b0, 1'b1, 1'b1, 5'h11, 8'h00);
    n_vec++; if (bus.DO !== 8'h00) begin n_err++; $display("FAIL edge_flag2 got %h want 00", bus.DO); end
    n_vec++; if (irq_n !== 1'b1) begin n_err++; $display("FAIL edge_irq_clr got %b want 1", irq_n); end
`else
    n_vec++; if (irq_n !== 1'b1) begin n_err++; $display("FAIL noedge_irq got %b want 1", irq_n); end
    cyc(1'b0, 1'b1, 1'b1, 5'h11, 8'h00);
    n_vec++; if (bus.DO !== 8'h00) begin n_err++; $display("FAIL noedge_flag got %h want 00", bus.DO); end
`endif
  endtask

  task automatic test_reset_mid();
    int bad;
    cyc(1'b1, 1'b0, 1'b1, 5'h00, 8'h00);
    pi = 16'h1234;
    cyc(1'b0, 1'b1, 1'b0, 5'h00, 8'h5A);
    cyc(1'b0, 1'b1, 1'b0, 5'h03, 8'hFF);
    cyc(1'b0, 1'b1, 1'b0, 5'h1C, 8'h40);   // prescale 1, IRQ enabled
    idle(3);
    cyc(1'b0, 1'b1, 1'b1, 5'h00, 8'h00);
    n_vec++; if (bus.DO !== 8'h34) begin n_err++; $display("FAIL rm_pre_read got %h want 34", bus.DO); end
    cyc(1'b1, 1'b1, 1'b1, 5'h1C, 8'h00);   // reset beats a same-cycle read
    n_vec++; if (bus.DO !== 8'h00) begin n_err++; $display("FAIL rm_do got %h want 00", bus.DO); end
    n_vec++; if (bus.OE !== 1'b0) begin n_err++; $display("FAIL rm_oe got %b want 0", bus.OE); end
    n_vec++; if ({po, ddr} !== 32'h0) begin n_err++; $display("FAIL rm_ports got %h want 0", {po, ddr}); end
    n_vec++; if (irq_n !== 1'b1) begin n_err++; $display("FAIL rm_irq got %b want 1", irq_n); end
    idle(5);
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, 1'b1, 5'h1C, 8'h00);
      if (bus.DO !== 8'h00) bad++;
    end
    idle(2);
    if (irq_n !== 1'b1) bad++;
    n_vec++; if (bad != 0) begin n_err++; $display("FAIL rm_frozen got %0d bad want 0", bad); end
  endtask

  task automatic test_random();
    logic [8*NP-1:0] exp_po, exp_ddr;
    logic r, c, w;
    logic [4:0] a;
    logic [7:0] di;
    int bad;
    cyc(1'b1, 1'b0, 1'b1, 5'h00, 8'h00);
    bad = 0;
    for (int n = 0; n < 3000; n++) begin
      pi = 16'($urandom);
      r  = ($urandom_range(0, 199) == 0);
      c  = ($urandom_range(0, 2) == 0);
      w  = 1'($urandom);
      a  = 5'($urandom);
      di = $urandom_range(0, 1) ? 8'($urandom_range(0, 15)) : 8'($urandom);
      cyc(r, c, w, a, di);
      for (int i = 0; i < NP; i++) begin
        exp_po[8*i +: 8]  = m_po[i];
        exp_ddr[8*i +: 8] = m_ddr[i];
      end
      n_vec++;
      if (bus.DO !== m_do || bus.OE !== m_oe || irq_n !== m_irq_n ||
          po !== exp_po || ddr !== exp_ddr) begin
        n_err++;
        bad++;
        if (bad <= 10)
          $display("FAIL rand[%0d] got do=%h oe=%b irq_n=%b po=%h ddr=%h want do=%h oe=%b irq_n=%b po=%h ddr=%h",
                   n, bus.DO, bus.OE, irq_n, po, ddr, m_do, m_oe, m_irq_n, exp_po, exp_ddr);
      end
    end
  endtask

  initial begin
    rst = 1'b1; bus.cs = 1'b0; bus.we_n = 1'b1; bus.A = '0; bus.DI = '0; pi = '0;
    test_reset();
    test_port_rw();
    test_timer_underflow();
    test_read_clear();
    test_write_at_underflow();
    test_edge();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout after 2ms");
    $fatal(1);
  end

endmodule
